mips_top: RTL and testbench

Single-cycle 32-bit MIPS subset processor with its own instruction and data memories. It is the top-level system block of the processor design. Each instruction fetches, decodes, executes and retires in exactly one clock cycle. The data-memory write port is exposed so a bench can observe stores.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/mips_core.sv | 139 +++++++++++++
 rtl/mips_top.sv | 39 +++
 tb/tb_mips_top.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the single-cycle MIPS subset.
// Holds opcodes, functs, the ALU-control enum, decode bundle and memory depth.
package mips_pkg;

    localparam int MEM_DEPTH = 64;
    localparam int MEM_AW    = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    reg_dst;
        logic    alu_src;
        logic    mem_write;
        logic    mem_to_reg;
        logic    branch;
        logic    jump;
        alu_op_e alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_core.sv
// mips_core: controller + datapath (PC, 32x32 register file, ALU).
// Ports: clk, reset (sync, active-high), imem_idx_o/instr_i fetch,
// memwrite_o/dataadr_o/writedata_o/readdata_i data-memory access.
// Optional MIPS_TRACE_EN: simulation trace of PC, instr and writes.
module mips_core
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [5:0]  imem_idx_o,
    input  logic [31:0] instr_i,
    output logic        memwrite_o,
    output logic [31:0] dataadr_o,
    output logic [31:0] writedata_o,
    input  logic [31:0] readdata_i
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    ctrl_t       ctrl;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wa;
    logic [31:0] imm_ext, rd1, rd2, srcb;
    logic [31:0] alu_res, wd, pc_plus4;
    logic        zero;
    logic        unused_shamt;

    assign op      = instr_i[31:26];
    assign rs      = instr_i[25:21];
    assign rt      = instr_i[20:16];
    assign rd      = instr_i[15:11];
    assign funct   = instr_i[5:0];
    assign imm_ext = {{16{instr_i[15]}}, instr_i[15:0]};

    assign unused_shamt = ^instr_i[10:6];

    // Unknown opcodes/functs leave every enable low: a NOP.
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: ctrl.reg_write = 1'b0;
                endcase
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OP_J:    ctrl.jump = 1'b1;
            default: ;
        endcase
    end

    // $0 is not reset, so force its reads to zero.
    assign rd1  = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rd2  = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign srcb = ctrl.alu_src ? imm_ext : rd2;

    always_comb begin
        case (ctrl.alu_op)
            ALU_ADD: alu_res = rd1 + srcb;
            ALU_SUB: alu_res = rd1 - srcb;
            ALU_AND: alu_res = rd1 & srcb;
            ALU_OR:  alu_res = rd1 | srcb;
            ALU_SLT: alu_res = {31'd0,
                                $signed(rd1) < $signed(srcb)};
            default: alu_res = rd1 + srcb;
        endcase
    end

    assign zero = (alu_res == 32'd0);
    assign wa   = ctrl.reg_dst ? rd : rt;
    assign wd   = ctrl.mem_to_reg ? readdata_i : alu_res;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_plus4;
        if (ctrl.jump)
            pc_d = {pc_plus4[31:28], instr_i[25:0], 2'b00};
        else if (ctrl.branch && zero)
            pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= 32'd0;
        else
            pc_q <= pc_d;
    end

    always_ff @(posedge clk) begin
        if (!reset && ctrl.reg_write && (wa != 5'd0))
            rf_q[wa] <= wd;
    end

    assign imem_idx_o  = pc_q[7:2];
    assign memwrite_o  = ctrl.mem_write & ~reset;
    assign dataadr_o   = alu_res;
    assign writedata_o = rd2;

`ifdef MIPS_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            $display("pc=%h instr=%h", pc_q, instr_i);
            if (ctrl.reg_write && (wa != 5'd0))
                $display("  r%0d <= %h", wa, wd);
            if (memwrite_o)
                $display("  m[%0d] <= %h",
                         dataadr_o[7:2], writedata_o);
        end
    end
`else
`endif

endmodule

// File: rtl/mips_top.sv
// mips_top: single-cycle MIPS system with 64-word imem and dmem.
// Ports: clk, reset (sync, active-high), writedata, dataadr, memwrite.
module mips_top
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] writedata,
    output logic [31:0] dataadr,
    output logic        memwrite
);

    logic [31:0] imem   [MEM_DEPTH];
    logic [31:0] dmem_q [MEM_DEPTH];

    logic [5:0]  imem_idx;
    logic [31:0] instr, readdata;

    assign instr    = imem[imem_idx];
    assign readdata = dmem_q[dataadr[7:2]];

    // memwrite is already gated by reset inside the core.
    always_ff @(posedge clk) begin
        if (memwrite)
            dmem_q[dataadr[7:2]] <= writedata;
    end

    mips_core u_core (
        .clk         (clk),
        .reset       (reset),
        .imem_idx_o  (imem_idx),
        .instr_i     (instr),
        .memwrite_o  (memwrite),
        .dataadr_o   (dataadr),
        .writedata_o (writedata),
        .readdata_i  (readdata)
    );

endmodule

// File: tb/tb_mips_top.sv
// tb_mips_top: directed programs plus random programs checked
// against an instruction-level model of the MIPS subset.
module tb_mips_top;

    logic        clk;
    logic        reset;
    logic [31:0] writedata;
    logic [31:0] dataadr;
    logic        memwrite;

    int checks;
    int errors;

    logic [31:0] prog  [64];
    logic [31:0] m_mem [64];
    logic [31:0] m_r   [32];
    logic [31:0] cap_a [$];
    logic [31:0] cap_d [$];

    mips_top dut (
        .clk       (clk),
        .reset     (reset),
        .writedata (writedata),
        .dataadr   (dataadr),
        .memwrite  (memwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];
    endtask

    // Called at negedge+1; the pending instruction never executes.
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic capture(input int n);
        cap_a.delete();
        cap_d.delete();
        for (int i = 0; i < n; i++) begin
            if (memwrite === 1'b1) begin
                cap_a.push_back(dataadr);
                cap_d.push_back(writedata);
            end
            step();
        end
    endtask

    task automatic set_std();
        logic [31:0] w [18];
        w = '{32'h20020005, 32'h2003000c, 32'h2067fff7,
              32'h00e22025, 32'h00642824, 32'h00a42820,
              32'h10a7000a, 32'h0064202a, 32'h10800001,
              32'h20050000, 32'h00e2202a, 32'h00853820,
              32'h00e23822, 32'hac670044, 32'h8c020050,
              32'h08000011, 32'h20020001, 32'hac020054};
        clear_prog();
        for (int i = 0; i < 18; i++) prog[i] = w[i];
    endtask

    task automatic test_reset();
        set_std();
        load_prog();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            checks++;
            if (memwrite !== 1'b0) begin
                errors++;
                $display("FAIL reset_memwrite got %b want 0",
                         memwrite);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dataadr !== 32'd5 || memwrite !== 1'b0) begin
            errors++;
            $display("FAIL first_instr got adr=%0d mw=%b want 5 0",
                     dataadr, memwrite);
        end
        step();
        checks++;
        if (dataadr !== 32'd12) begin
            errors++;
            $display("FAIL second_instr got %0d want 12", dataadr);
        end
    endtask

    task automatic test_standard();
        set_std();
        load_prog();
        do_reset();
        capture(60);
        checks++;
        if (cap_a.size() != 2) begin
            errors++;
            $display("FAIL std_count got %0d want 2", cap_a.size());
        end
        if (cap_a.size() >= 1) begin
            checks++;
            if (cap_a[0] !== 32'd80 || cap_d[0] !== 32'd7) begin
                errors++;
                $display("FAIL std_st0 got %0d/%0d want 80/7",
                         cap_a[0], cap_d[0]);
            end
        end
        if (cap_a.size() >= 2) begin
            checks++;
            if (cap_a[1] !== 32'd84 || cap_d[1] !== 32'd7) begin
                errors++;
                $display("FAIL std_st1 got %0d/%0d want 84/7",
                         cap_a[1], cap_d[1]);
            end
        end
    endtask

    task automatic test_zero_reg();
        clear_prog();
        prog[0] = 32'h20000009;
        prog[1] = 32'hac000000;
        prog[2] = 32'h08000002;
        load_prog();
        do_reset();
        step();
        checks++;
        if (memwrite !== 1'b1 || writedata !== 32'd0 ||
            dataadr !== 32'd0) begin
            errors++;
            $display("FAIL zero_reg got mw=%b wd=%h adr=%h want 1 0 0",
                     memwrite, writedata, dataadr);
        end
    endtask

    task automatic test_beq();
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        ea = '{32'd4, 32'd8, 32'd16};
        ed = '{32'd3, 32'd4, 32'd4};
        clear_prog();
        prog[0] = 32'h20010003;
        prog[1] = 32'h20020004;
        prog[2] = 32'h10220001;
        prog[3] = 32'hac010004;
        prog[4] = 32'hac020008;
        prog[5] = 32'h20030004;
        prog[6] = 32'h10430001;
        prog[7] = 32'hac01000c;
        prog[8] = 32'hac020010;
        prog[9] = 32'h08000009;
        load_prog();
        do_reset();
        capture(14);
        checks++;
        if (cap_a.size() != 3) begin
            errors++;
            $display("FAIL beq_count got %0d want 3", cap_a.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < cap_a.size()) begin
                checks++;
                if (cap_a[i] !== ea[i] || cap_d[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL beq_st%0d got %0d/%0d want %0d/%0d",
                             i, cap_a[i], cap_d[i], ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_slt();
        clear_prog();
        prog[0] = 32'h2001ffff;
        prog[1] = 32'h20020001;
        prog[2] = 32'h0022182a;
        prog[3] = 32'hac030000;
        prog[4] = 32'h0041202a;
        prog[5] = 32'hac040004;
        prog[6] = 32'h08000006;
        load_prog();
        do_reset();
        capture(10);
        checks++;
        if (cap_a.size() != 2) begin
            errors++;
            $display("FAIL slt_count got %0d want 2", cap_a.size());
        end else begin
            checks++;
            if (cap_a[0] !== 32'd0 || cap_d[0] !== 32'd1) begin
                errors++;
                $display("FAIL slt_lt got %0d/%0d want 0/1",
                         cap_a[0], cap_d[0]);
            end
            checks++;
            if (cap_a[1] !== 32'd4 || cap_d[1] !== 32'd0) begin
                errors++;
                $display("FAIL slt_ge got %0d/%0d want 4/0",
                         cap_a[1], cap_d[1]);
            end
        end
    endtask

    task automatic test_fill();
        clear_prog();
        prog[0] = 32'h20020000;
        prog[1] = 32'h20030100;
        prog[2] = 32'hac420000;
        prog[3] = 32'h20420004;
        prog[4] = 32'h10430001;
        prog[5] = 32'h08000002;
        prog[6] = 32'h08000006;
        load_prog();
        do_reset();
        capture(300);
        checks++;
        if (cap_a.size() != 64) begin
            errors++;
            $display("FAIL fill_count got %0d want 64", cap_a.size());
        end
        for (int i = 0; i < cap_a.size() && i < 64; i++) begin
            checks++;
            if (cap_a[i] !== 32'(i * 4) ||
                cap_d[i] !== 32'(i * 4)) begin
                errors++;
                $display("FAIL fill_st%0d got %0d/%0d want %0d",
                         i, cap_a[i], cap_d[i], i * 4);
            end
        end
    endtask

    task automatic test_mid_reset();
        clear_prog();
        prog[0] = 32'h8c020030;
        prog[1] = 32'h20420001;
        prog[2] = 32'hac020030;
        load_prog();
        do_reset();
        checks++;
        if (dataadr !== 32'h30) begin
            errors++;
            $display("FAIL mr_lw got %h want 30", dataadr);
        end
        step();
        checks++;
        if (dataadr !== 32'h31) begin
            errors++;
            $display("FAIL mr_inc got %h want 31", dataadr);
        end
        step();
        checks++;
        if (memwrite !== 1'b1 || writedata !== 32'h31) begin
            errors++;
            $display("FAIL mr_sw got mw=%b wd=%h want 1 31",
                     memwrite, writedata);
        end
        repeat (3) step();
        do_reset();
        checks++;
        if (dataadr !== 32'h30) begin
            errors++;
            $display("FAIL mr_restart got %h want 30", dataadr);
        end
        step();
        checks++;
        if (dataadr !== 32'h32) begin
            errors++;
            $display("FAIL mr_persist got %h want 32", dataadr);
        end
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (memwrite !== 1'b0) begin
            errors++;
            $display("FAIL mr_sw_in_reset got %b want 0", memwrite);
        end
        do_reset();
        step();
        checks++;
        if (dataadr !== 32'h32) begin
            errors++;
            $display("FAIL mr_no_store got %h want 32", dataadr);
        end
        step();
        checks++;
        if (memwrite !== 1'b1 || writedata !== 32'h32) begin
            errors++;
            $display("FAIL mr_sw2 got mw=%b wd=%h want 1 32",
                     memwrite, writedata);
        end
        step();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  fns [5];
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int          k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        k   = $urandom_range(0, 9);
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        case (k)
            0, 1: return {6'h00, rs, rt, rd, 5'd0,
                          fns[$urandom_range(0, 4)]};
            2: return {6'h00, rs, rt, rd, 5'($urandom),
                       6'($urandom)};
            3, 9: return {6'h08, rs, rt, imm};
            4: return {6'h23, rs, rt, imm};
            5: return {6'h2b, rs, rt, imm};
            6: return {6'h04, rs, rt,
                       16'($urandom_range(0, 12)) - 16'd6};
            7: return {6'h02, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] ins, a, b, simm, res, pc4, nxt, wval, m_pc;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, wreg;
        logic        exp_mw, da_ok, wr;
        for (int i = 0; i < 64; i++) m_mem[i] = 32'(i * 4);
        m_mem[12] = 32'h32;
        for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 7; k++)
                prog[k] = {6'h08, 5'd0, 5'(k + 1), 16'($urandom)};
            for (int k = 7; k < 64; k++) prog[k] = rand_instr();
            load_prog();
            do_reset();
            m_pc = 32'd0;
            for (int c = 0; c < 150; c++) begin
                ins  = prog[m_pc[7:2]];
                op   = ins[31:26];
                rs   = ins[25:21];
                rt   = ins[20:16];
                rd   = ins[15:11];
                fn   = ins[5:0];
                simm = {{16{ins[15]}}, ins[15:0]};
                a    = (rs == 5'd0) ? 32'd0 : m_r[rs];
                b    = (rt == 5'd0) ? 32'd0 : m_r[rt];
                pc4  = m_pc + 32'd4;
                nxt  = pc4;
                res  = 32'd0;
                wval = 32'd0;
                wreg = 5'd0;
                exp_mw = 1'b0;
                da_ok  = 1'b0;
                wr     = 1'b0;
                case (op)
                    6'h00: begin
                        da_ok = 1'b1;
                        wr    = 1'b1;
                        wreg  = rd;
                        case (fn)
                            6'h20: res = a + b;
                            6'h22: res = a - b;
                            6'h24: res = a & b;
                            6'h25: res = a | b;
                            6'h2a: res = ($signed(a) < $signed(b))
                                         ? 32'd1 : 32'd0;
                            default: begin
                                da_ok = 1'b0;
                                wr    = 1'b0;
                            end
                        endcase
                        wval = res;
                    end
                    6'h08: begin
                        res = a + simm;
                        da_ok = 1'b1;
                        wr = 1'b1;
                        wreg = rt;
                        wval = res;
                    end
                    6'h23: begin
                        res = a + simm;
                        da_ok = 1'b1;
                        wr = 1'b1;
                        wreg = rt;
                        wval = m_mem[res[7:2]];
                    end
                    6'h2b: begin
                        res = a + simm;
                        da_ok = 1'b1;
                        exp_mw = 1'b1;
                    end
                    6'h04: if (a == b) nxt = pc4 + (simm << 2);
                    6'h02: nxt = {pc4[31:28], ins[25:0], 2'b00};
                    default: ;
                endcase
                checks++;
                if (memwrite !== exp_mw) begin
                    errors++;
                    $display("FAIL rnd_mw p%0d c%0d ins=%h got %b want %b",
                             p, c, ins, memwrite, exp_mw);
                end
                if (c >= 7) begin
                    checks++;
                    if (writedata !== b) begin
                        errors++;
                        $display("FAIL rnd_wd p%0d c%0d ins=%h got %h want %h",
                                 p, c, ins, writedata, b);
                    end
                end
                if (da_ok) begin
                    checks++;
                    if (dataadr !== res) begin
                        errors++;
                        $display("FAIL rnd_adr p%0d c%0d ins=%h got %h want %h",
                                 p, c, ins, dataadr, res);
                    end
                end
                if (exp_mw) m_mem[res[7:2]] = b;
                if (wr && wreg != 5'd0) m_r[wreg] = wval;
                m_pc = nxt;
                step();
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_standard();
        test_zero_reg();
        test_beq();
        test_slt();
        test_fill();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
